operand_fetch_seq: RTL
======================

# operand_fetch_seq

Sequencer that fetches up to two source operands (rs1, rs2) through the register file's single combinational read port over consecutive cycles. It sits between the decode stage and the execute stage of the multicycle core. It accepts one fetch request at a time and returns both 32-bit operands together. It also bypasses a register-file write landing in the same cycle as a read, so operands are never stale.

## Interface
- XLEN, 32, operand/data width
- AW, 5, register address width (32 registers, x0 hardwired zero)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  fetch request present
- req_ready  out  1  sequencer can accept a request
- req_rs1  in  AW  first source register
- req_rs2  in  AW  second source register
- req_use_rs2  in  1  1 = fetch rs2; 0 = single-operand instruction
- rf_read_reg  out  AW  drives register file read address
- rf_read_data  in  XLEN  register file read data (combinational, zero for x0)
- wb_reg_write  in  1  write-port enable, monitored for bypass (same signal the register file sees)
- wb_write_reg  in  AW  write-port address
- wb_write_data  in  XLEN  write-port data
- op_valid  out  1  operands available
- op_ready  in  1  consumer accepts operands
- op_rs1_data  out  XLEN  captured rs1 value
- op_rs2_data  out  XLEN  captured rs2 value (0 when req_use_rs2 was 0)

## Operation
- FSM states: IDLE, RD1, RD2, DONE.
- IDLE:
  - req_ready=1 and rf_read_reg=0.
  - On req_valid, latch rs1, rs2 and use_rs2, then go to RD1.
- RD1:
  - rf_read_reg=rs1_q.
  - At the clock edge, capture the rs1 operand, then go to RD2 if use_rs2_q, else to DONE.
  - When use_rs2_q=0, also clear op_rs2_data to 0.
- RD2:
  - rf_read_reg=rs2_q.
  - At the clock edge, capture the rs2 operand, then go to DONE.
- DONE:
  - op_valid=1, rf_read_reg=0.
  - On op_ready, go to IDLE.
  - op_rs1_data and op_rs2_data hold stable until the handshake completes.
- Capture rule, applied in RD1 and RD2 with r as the register being read:
  - If wb_reg_write=1, wb_write_reg==r and r!=0, capture wb_write_data (bypass).
  - Otherwise capture rf_read_data.
- Reads of x0 always capture 0, whatever the write port is doing.
- Operands are snapshots taken at capture time. Writes after the capture cycle do not change held values.
- req_ready = (state==IDLE). op_valid = (state==DONE). Both decode directly from state with no combinational path from inputs.
- Requests arriving while req_ready=0 are ignored. The requester must hold req_valid.

## Timing
- Reset (rst=1 at an edge), taking effect at that edge:
  - state=IDLE, so req_ready=1 and op_valid=0.
  - op_rs1_data=0, op_rs2_data=0, rf_read_reg=0.
  - Latched rs1/rs2/use_rs2 are cleared.
- Reset mid-operation (any state) abandons the fetch. No op_valid pulse is produced.
- Latency from the accepting edge (cycle 0) to op_valid:
  - use_rs2=1: op_valid high in cycle 3 (RD1 in cycle 1, RD2 in cycle 2).
  - use_rs2=0: op_valid high in cycle 2.
- Throughput:
  - Back-to-back with op_ready held high: one request per 4 cycles (two operands) or 3 cycles (one operand).
  - The DONE→IDLE edge and the next accept are separate cycles.
- op_ready is sampled only in DONE. A stall of N cycles extends DONE by N cycles.
- When rs1==rs2, the port is still read twice. Each read applies the capture rule independently.

## Test plan
- Reset, then a request with rs1=3, rs2=5, use_rs2=1, where x3=0x11, x5=0x22 and op_ready=1 -> rf_read_reg is 3 in cycle 1 and 5 in cycle 2; in cycle 3 op_valid=1 with op_rs1_data=0x11, op_rs2_data=0x22; req_ready=1 again in cycle 4.
- Request with rs1=7, use_rs2=0, x7=0xDEAD -> op_valid in cycle 2 with op_rs1_data=0xDEAD and op_rs2_data=0.
- Bypass: request rs1=4, rs2=4, with a write of x4=0xCAFE asserted during RD1 and old x4=0x1 -> op_rs1_data=0xCAFE; op_rs2_data=0xCAFE (now read from the register file). A write to x4 during DONE leaves outputs at 0xCAFE.
- x0: rs1=0, rs2=0, with a write of x0=0xFFFF during RD1 and RD2 -> both operands are 0.
- Backpressure: op_ready=0 for 5 cycles in DONE while req_valid stays high with a new request -> op_valid and data remain stable, req_ready=0; the new request is accepted only after op_ready=1 and the return to IDLE.
- Reset asserted in RD2 -> the next cycle shows IDLE, op_valid=0, op_rs1_data=0 and req_ready=1. A following request completes normally.

Source files
------------

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: reads rs1 then (optionally) rs2 through one register-file
// read port, with same-cycle write bypass, and presents both operands together.
module operand_fetch_seq #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  input  logic            req_use_rs2,
  output logic [AW-1:0]   rf_read_reg,
  input  logic [XLEN-1:0] rf_read_data,
  input  logic            wb_reg_write,
  input  logic [AW-1:0]   wb_write_reg,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_rs1_data,
  output logic [XLEN-1:0] op_rs2_data
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   rs1_q, rs2_q;
  logic            use_rs2_q;
  logic [XLEN-1:0] cap_data;

  assign req_ready = (state == IDLE);
  assign op_valid  = (state == DONE);

  always_comb begin
    state_nxt   = state;
    rf_read_reg = '0;
    case (state)
      IDLE: if (req_valid) state_nxt = RD1;
      RD1: begin
        rf_read_reg = rs1_q;
        state_nxt   = use_rs2_q ? RD2 : DONE;
      end
      RD2: begin
        rf_read_reg = rs2_q;
        state_nxt   = DONE;
      end
      DONE: if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A write landing on the register being read wins over the stale port data; x0 stays zero.
  always_comb begin
    cap_data = '0;
    if (rf_read_reg != '0) begin
      if (wb_reg_write && (wb_write_reg == rf_read_reg)) cap_data = wb_write_data;
      else                                               cap_data = rf_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_rs2_q   <= 1'b0;
      op_rs1_data <= '0;
      op_rs2_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          rs1_q     <= req_rs1;
          rs2_q     <= req_rs2;
          use_rs2_q <= req_use_rs2;
        end
        RD1: begin
          op_rs1_data <= cap_data;
          if (!use_rs2_q) op_rs2_data <= '0;
        end
        RD2: op_rs2_data <= cap_data;
        default: ;
      endcase
    end
  end

endmodule
